// File: rtl/dp_pkg.sv
// Shared types for the pipelined datapath: ALU opcodes, command controls and stage records.
package dp_pkg;

  localparam int DATA_W     = 16;
  localparam int RF_DEPTH   = 16;
  localparam int DMEM_DEPTH = 256;
  localparam int RF_AW      = $clog2(RF_DEPTH);
  localparam int DM_AW      = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    ALU_ZERO = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op_e;

  // Width-independent command controls; addresses and data live beside them sized by module parameters.
  typedef struct packed {
    alu_op_e alu;
    logic    we;
    logic    rf_s;
    logic    dwr;
  } dp_cmd_t;

  typedef struct packed {
    logic    valid;
    dp_cmd_t ctl;
  } ex_stage_t;

  typedef struct packed {
    logic valid;
    logic rf_s;
  } wb_stage_t;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port with
// write-through to the readers, and asynchronous clear of every register.
module dp_regfile #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16,
  localparam int AW      = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra_a,
  output logic [DATA_W-1:0] rd_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs_r [RF_DEPTH];

  // Register array write with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) regs_r[i] <= '0;
    end else if (we) begin
      regs_r[wa] <= wd;
    end
  end

  // Read ports see a same-cycle write immediately
  always_comb begin
    rd_a = regs_r[ra_a];
    rd_b = regs_r[ra_b];
    if (we && (wa == ra_a)) rd_a = wd;
    else                    rd_a = regs_r[ra_a];
    if (we && (wa == ra_b)) rd_b = wd;
    else                    rd_b = regs_r[ra_b];
  end

endmodule

// File: rtl/pipelined_datapath.sv
// ID/EX/WB datapath with register file, inline ALU and single-port data RAM.
// Build macro DP_FWD_EN enables EX-result bypassing; without it RAW hazards on EX stall.
module pipelined_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int RF_DEPTH   = 16,
  parameter int DMEM_DEPTH = 256,
  localparam int RF_AW     = $clog2(RF_DEPTH),
  localparam int DM_AW     = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_alu,
  input  logic [RF_AW-1:0]  cmd_ra,
  input  logic [RF_AW-1:0]  cmd_rb,
  input  logic [RF_AW-1:0]  cmd_wa,
  input  logic              cmd_we,
  input  logic              cmd_rf_s,
  input  logic [DM_AW-1:0]  cmd_daddr,
  input  logic              cmd_dwr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [RF_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  ex_stage_t         ex_r;
  logic [RF_AW-1:0]  ex_wa_r;
  logic [DM_AW-1:0]  ex_daddr_r;
  logic [DATA_W-1:0] ex_a_r, ex_b_r;
  wb_stage_t         wb_r;
  logic [RF_AW-1:0]  wb_wa_r;
  logic [DATA_W-1:0] wb_res_r, ram_q_r;
  logic [DATA_W-1:0] mem [DMEM_DEPTH];

  logic [DATA_W-1:0] rf_a_s, rf_b_s, opa_s, opb_s, alu_s, wb_data_s;
  logic              hit_a_s, hit_b_s, stall_s, accept_s;

  assign wb_data_s = wb_r.rf_s ? ram_q_r : wb_res_r;

  dp_regfile #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wb_r.valid),
    .wa   (wb_wa_r),
    .wd   (wb_data_s),
    .ra_a (cmd_ra),
    .rd_a (rf_a_s),
    .ra_b (cmd_rb),
    .rd_b (rf_b_s)
  );

  // ALU on the EX operand registers
  always_comb begin
    alu_s = '0;
    case (ex_r.ctl.alu)
      ALU_ZERO: alu_s = '0;
      ALU_ADD:  alu_s = ex_a_r + ex_b_r;
      ALU_SUB:  alu_s = ex_a_r - ex_b_r;
      ALU_PASS: alu_s = ex_a_r;
      ALU_AND:  alu_s = ex_a_r & ex_b_r;
      ALU_OR:   alu_s = ex_a_r | ex_b_r;
      ALU_XOR:  alu_s = ex_a_r ^ ex_b_r;
      ALU_INC:  alu_s = ex_a_r + {{(DATA_W-1){1'b0}}, 1'b1};
      default:  alu_s = '0;
    endcase
  end

  // Hazard detection and operand selection in ID; WB bypass comes from RF write-through
  always_comb begin
    hit_a_s = ex_r.valid && ex_r.ctl.we && (ex_wa_r == cmd_ra);
    hit_b_s = ex_r.valid && ex_r.ctl.we && (ex_wa_r == cmd_rb);
    opa_s   = rf_a_s;
    opb_s   = rf_b_s;
`ifdef DP_FWD_EN
    stall_s = cmd_valid && ex_r.ctl.rf_s && (hit_a_s || hit_b_s);
    if (hit_a_s && !ex_r.ctl.rf_s) opa_s = alu_s;
    else                           opa_s = rf_a_s;
    if (hit_b_s && !ex_r.ctl.rf_s) opb_s = alu_s;
    else                           opb_s = rf_b_s;
`else
    stall_s = cmd_valid && (hit_a_s || hit_b_s);
`endif
    accept_s = cmd_valid && !stall_s;
  end

  // EX stage registers; a non-accepted cycle inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r       <= '0;
      ex_wa_r    <= '0;
      ex_daddr_r <= '0;
      ex_a_r     <= '0;
      ex_b_r     <= '0;
    end else if (accept_s) begin
      ex_r.valid    <= 1'b1;
      ex_r.ctl.alu  <= alu_op_e'(cmd_alu);
      ex_r.ctl.we   <= cmd_we;
      ex_r.ctl.rf_s <= cmd_rf_s;
      ex_r.ctl.dwr  <= cmd_dwr;
      ex_wa_r       <= cmd_wa;
      ex_daddr_r    <= cmd_daddr;
      ex_a_r        <= opa_s;
      ex_b_r        <= opb_s;
    end else begin
      ex_r.valid <= 1'b0;
    end
  end

  // WB stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r     <= '0;
      wb_wa_r  <= '0;
      wb_res_r <= '0;
    end else begin
      wb_r.valid <= ex_r.valid && ex_r.ctl.we;
      wb_r.rf_s  <= ex_r.ctl.rf_s;
      wb_wa_r    <= ex_wa_r;
      wb_res_r   <= alu_s;
    end
  end

  // Data RAM: read returns the pre-write word on an address collision
  always_ff @(posedge clk) begin
    ram_q_r <= mem[ex_daddr_r];
    if (ex_r.valid && ex_r.ctl.dwr) mem[ex_daddr_r] <= ex_a_r;
  end

  assign cmd_ready = !stall_s;
  assign ra_data   = ex_a_r;
  assign rb_data   = ex_b_r;
  assign alu_out   = alu_s;
  assign wb_valid  = wb_r.valid;
  assign wb_addr   = wb_wa_r;
  assign wb_data   = wb_data_s;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench for pipelined_datapath; builds with or without DP_FWD_EN.
module tb_pipelined_datapath;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_rf_s, cmd_dwr;
  logic [2:0]  cmd_alu;
  logic [3:0]  cmd_ra, cmd_rb, cmd_wa;
  logic [7:0]  cmd_daddr;
  logic [15:0] ra_data, rb_data, alu_out, wb_data;
  logic        wb_valid;
  logic [3:0]  wb_addr;

  always #5 clk = ~clk;

  pipelined_datapath dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_alu(cmd_alu), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wa(cmd_wa),
    .cmd_we(cmd_we), .cmd_rf_s(cmd_rf_s), .cmd_daddr(cmd_daddr), .cmd_dwr(cmd_dwr),
    .ra_data(ra_data), .rb_data(rb_data), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct { logic [3:0] a; logic [15:0] d; } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  exp_t        sb[$];
  logic [15:0] m_rf [16];
  logic [15:0] m_mem [256];
  logic [15:0] mem_snap [256];

`ifdef DP_FWD_EN
  localparam int DEP_STALLS = 0;
`else
  localparam int DEP_STALLS = 1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      3'd7:    return a + 16'd1;
      default: return 16'd0;
    endcase
  endfunction

  // Drive one command, hold it through stalls, update the model once on acceptance
  task automatic issue(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] wa, input logic we, input logic rf_s,
                       input logic [7:0] da, input logic dwr);
    int   waited = 0;
    bit   ok = 1'b1;
    exp_t e;
    logic [15:0] a, b, ld;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_alu = op; cmd_ra = ra; cmd_rb = rb; cmd_wa = wa;
    cmd_we = we; cmd_rf_s = rf_s; cmd_daddr = da; cmd_dwr = dwr;
    #1;
    while (!cmd_ready) begin
      stall_cnt++;
      waited++;
      if (waited > 8) begin
        check("ready_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (ok) begin
      a  = m_rf[ra];
      b  = m_rf[rb];
      ld = m_mem[da];
      if (dwr) m_mem[da] = a;
      if (we) begin
        e.a = wa;
        e.d = rf_s ? ld : alu_ref(op, a, b);
        m_rf[wa] = e.d;
        sb.push_back(e);
      end
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] r, input logic [15:0] exp, input string tag);
    issue(3'd3, r, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    check(tag, ra_data, exp);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  // Scoreboard: every WB write must match the next expected write in order
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_addr", wb_addr, e.a);
        check("wb_data", wb_data, e.d);
      end
    end
  end

  initial begin
    int s0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_alu = 3'd0; cmd_ra = 4'd0; cmd_rb = 4'd0;
    cmd_wa = 4'd0; cmd_we = 1'b0; cmd_rf_s = 1'b0; cmd_daddr = 8'd0; cmd_dwr = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_wb_valid", wb_valid, 32'd0);
    check("rst_ready", cmd_ready, 32'd1);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_ra_data", ra_data, 32'd0);
    rst_n = 1'b1;

    // Clear the RAM by storing R0 everywhere
    for (int i = 0; i < 256; i++) issue(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'(i), 1'b1);

    // Reset mid-stream with a store sitting in EX
    issue(3'd7, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 8'd0, 1'b0);
    issue(3'd7, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 256; i++) mem_snap[i] = m_mem[i];
    issue(3'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 8'h30, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = mem_snap[i];
    #1;
    check("midrst_wb_valid", wb_valid, 32'd0);
    check("midrst_ready", cmd_ready, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) read_reg(4'(i), 16'd0, "rst_rf_zero");

    // Back-to-back dependent ALU ops
    s0 = stall_cnt;
    issue(3'd7, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 8'd0, 1'b0);
    issue(3'd1, 4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 8'd0, 1'b0);
    check("incadd_stalls", stall_cnt - s0, DEP_STALLS);
    drain();
    read_reg(4'd2, 16'd2, "r2_value");

    // Store, load from the same word, then use the load result
    s0 = stall_cnt;
    issue(3'd0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 8'h2A, 1'b1);
    issue(3'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 8'h2A, 1'b0);
    issue(3'd1, 4'd3, 4'd3, 4'd4, 1'b1, 1'b0, 8'd0, 1'b0);
    check("loaduse_stalls", stall_cnt - s0, 32'd1);
    drain();
    read_reg(4'd4, 16'd4, "r4_value");

    // Subtraction underflow and increment wrap
    issue(3'd2, 4'd0, 4'd1, 4'd5, 1'b1, 1'b0, 8'd0, 1'b0);
    issue(3'd7, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 8'd0, 1'b0);
    drain();
    read_reg(4'd5, 16'hFFFF, "sub_wrap");
    read_reg(4'd6, 16'h0000, "inc_wrap");

    // Random command stream
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) @(negedge clk);
      issue(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            8'($urandom_range(15)), ($urandom_range(3) == 0));
    end
    drain();

    // Final architectural state: registers, then every RAM word via loads
    for (int i = 0; i < 16; i++) read_reg(4'(i), m_rf[i], "final_rf");
    for (int i = 0; i < 256; i++) issue(3'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 8'(i), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
